// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM states and the default NOP word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect logic: decides whether control flow leaves the
// sequential path and which target wins (taken branch beats jump).
module next_pc_calc (
  input  logic [3:0]  pc_hi,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        alu_zero,
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm,
  input  logic [25:0] j_index,
  output logic        redirect,
  output logic [31:0] target
);

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] j_target;

  always_comb begin
    br_taken  = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);
    br_target = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    j_target  = {pc_hi, j_index, 2'b00};
    redirect  = br_taken | jump;
    target    = br_taken ? br_target : j_target;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding req/ack fetch at a time, registered
// outputs to ID, PC redirect on taken branch or jump.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         id_stall,
  input  logic         branch_eq,
  input  logic         branch_ne,
  input  logic         jump,
  input  logic         alu_zero,
  input  logic [31:0]  br_pc4,
  input  logic [15:0]  br_imm,
  input  logic [25:0]  j_index,
  output logic [31:0]  instr,
  output logic [5:0]   opcode,
  output logic [31:0]  pc_plus4,
  output logic         instr_valid,
  output fetch_state_e fetch_state
);

  // Handshake: imem_req rises one cycle after entering S_REQ and holds with a
  // stable imem_addr until the single-cycle imem_ack; acks elsewhere are ignored.

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n, pc_seq;
  logic [31:0]  addr_n, instr_n, pc4_n;
  logic         req_n, valid_n, discard, discard_n;
  logic         redirect;
  logic [31:0]  target;

  next_pc_calc u_next_pc_calc (
    .pc_hi     (pc[31:28]),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .jump      (jump),
    .alu_zero  (alu_zero),
    .br_pc4    (br_pc4),
    .br_imm    (br_imm),
    .j_index   (j_index),
    .redirect  (redirect),
    .target    (target)
  );

  assign pc_seq      = pc + 32'd4;
  assign fetch_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_n     = imem_req;
    addr_n    = imem_addr;
    instr_n   = instr;
    pc4_n     = pc_plus4;
    valid_n   = instr_valid;
    discard_n = discard;
    case (state)
      S_REQ: begin
        if (redirect) begin
          pc_n    = target;
          instr_n = NOP_WORD;
          valid_n = 1'b0;
        end else begin
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_n     = 1'b0;
          discard_n = 1'b0;
          state_n   = S_REQ;
          if (redirect) begin
            pc_n    = target;
            instr_n = NOP_WORD;
            valid_n = 1'b0;
          end else if (!discard) begin
            instr_n = imem_rdata;
            pc4_n   = pc_seq;
            pc_n    = pc_seq;
            valid_n = 1'b1;
            state_n = S_VALID;
          end
        end else if (redirect) begin
          // Request already in flight: keep req/addr, drop its data on arrival.
          pc_n      = target;
          instr_n   = NOP_WORD;
          valid_n   = 1'b0;
          discard_n = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect) begin
          pc_n    = target;
          instr_n = NOP_WORD;
          valid_n = 1'b0;
          state_n = S_REQ;
        end else if (!id_stall) begin
          instr_n = NOP_WORD;
          valid_n = 1'b0;
          state_n = S_REQ;
        end
      end
      default: begin
        state_n   = S_REQ;
        req_n     = 1'b0;
        instr_n   = NOP_WORD;
        valid_n   = 1'b0;
        discard_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= NOP_WORD;
      opcode      <= 6'd0;
      pc_plus4    <= 32'd0;
      instr_valid <= 1'b0;
      discard     <= 1'b0;
    end else begin
      pc          <= pc_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      instr       <= instr_n;
      opcode      <= opcode_of(instr_n);
      pc_plus4    <= pc4_n;
      instr_valid <= valid_n;
      discard     <= discard_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with variable latency,
// request/output monitors popping expected-value queues.
module tb_fetch_unit;
  import mips_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         id_stall;
  logic         branch_eq, branch_ne, jump, alu_zero;
  logic [31:0]  br_pc4;
  logic [15:0]  br_imm;
  logic [25:0]  j_index;
  logic [31:0]  instr;
  logic [5:0]   opcode;
  logic [31:0]  pc_plus4;
  logic         instr_valid;
  fetch_state_e fetch_state;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_stall    (id_stall),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .jump        (jump),
    .alu_zero    (alu_zero),
    .br_pc4      (br_pc4),
    .br_imm      (br_imm),
    .j_index     (j_index),
    .instr       (instr),
    .opcode      (opcode),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .fetch_state (fetch_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int lat     = 1;
  int wcnt    = 0;
  bit stray_ack = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_out_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0005 + a;
  endfunction

  // instruction memory model: ack after lat cycles of visible request
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_ack) begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end else if (stray_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        stray_ack  = 1'b0;
        wcnt       = 0;
      end else if (imem_req === 1'b1) begin
        wcnt++;
        if (wcnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // scoreboard: request addresses and address stability
  logic        prev_req = 1'b0;
  logic [31:0] held_addr = 32'd0;
  always @(negedge clk) begin
    if (imem_req === 1'b1 && !prev_req) begin
      check("req_expected", exp_addr_q.size() != 0, 1'b1);
      if (exp_addr_q.size() != 0) check("req_addr", imem_addr, exp_addr_q.pop_front());
      held_addr = imem_addr;
    end else if (imem_req === 1'b1 && prev_req) begin
      check("addr_stable", imem_addr, held_addr);
    end
    prev_req = (imem_req === 1'b1);
  end

  // scoreboard: delivered instructions
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (instr_valid === 1'b1 && !prev_valid) begin
      check("out_expected", exp_out_q.size() != 0, 1'b1);
      if (exp_out_q.size() != 0) begin
        e = exp_out_q.pop_front();
        check("instr", instr, e[63:32]);
        check("opcode", opcode, e[63:58]);
        check("pc_plus4", pc_plus4, e[31:0]);
      end
    end
    prev_valid = (instr_valid === 1'b1);
  end

  // driver tasks
  task automatic push_fetch(input logic [31:0] a, input bit delivered);
    exp_addr_q.push_back(a);
    if (delivered) exp_out_q.push_back({mem_word(a), a + 32'd4});
  endtask

  task automatic release_stall();
    @(negedge clk);
    id_stall = 1'b0;
    @(negedge clk);
    id_stall = 1'b1;
  endtask

  task automatic wait_req_rise();
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_timeout", imem_req, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", instr_valid, 1'b1);
  endtask

  task automatic drive_redirect(input logic beq, input logic bne, input logic jmp, input logic z,
                                input logic [31:0] pc4, input logic [15:0] imm, input logic [25:0] idx);
    branch_eq = beq; branch_ne = bne; jump = jmp; alu_zero = z;
    br_pc4 = pc4; br_imm = imm; j_index = idx;
    @(negedge clk);
    branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0;
    alu_zero = 1'($urandom_range(0, 1));
    br_pc4 = $urandom; br_imm = 16'($urandom); j_index = 26'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_opcode"}, opcode, 6'd0);
    check({tag, "_pc4"}, pc_plus4, 32'd0);
    check({tag, "_valid"}, instr_valid, 1'b0);
    check({tag, "_state"}, fetch_state, S_REQ);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; id_stall = 1'b1;
    branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0; alu_zero = 1'b0;
    br_pc4 = 32'd0; br_imm = 16'd0; j_index = 26'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    // first fetch, latency 1
    lat = 1;
    push_fetch(32'h0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("req_cycle1", imem_req, 1'b1);
    check("req_state", fetch_state, S_WAIT);
    wait_valid();
    check("first_opcode", opcode, OP_ADDI);

    // stall holds outputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_instr", instr, 32'h2008_0005);
      check("stall_opcode", opcode, 6'b001000);
      check("stall_pc4", pc_plus4, 32'd4);
      check("stall_req", imem_req, 1'b0);
      check("stall_valid", instr_valid, 1'b1);
    end
    push_fetch(32'h4, 1'b1);
    release_stall();
    check("unstall_state", fetch_state, S_REQ);
    check("unstall_valid", instr_valid, 1'b0);
    @(negedge clk);
    check("unstall_req", imem_req, 1'b1);
    wait_valid();

    // latency 4: request held four cycles, one ack consumed
    lat = 4;
    push_fetch(32'h8, 1'b1);
    release_stall();
    wait_req_rise();
    cnt = 1;
    while (cnt < 50) begin
      @(negedge clk);
      if (imem_req !== 1'b1) break;
      cnt++;
    end
    check("req_hold_cycles", cnt, 4);
    wait_valid();

    // taken beq during S_WAIT: in-flight data dropped, refetch from 0
    lat = 6;
    push_fetch(32'hC, 1'b0);
    release_stall();
    wait_req_rise();
    drive_redirect(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 16'hFFFC, 26'h0);
    check("discard_state", fetch_state, S_WAIT);
    check("discard_req", imem_req, 1'b1);
    check("discard_valid", instr_valid, 1'b0);
    push_fetch(32'h0, 1'b1);
    wait_valid();

    // bne with alu_zero=1: not taken, normal completion
    lat = 2;
    push_fetch(32'h4, 1'b1);
    release_stall();
    wait_req_rise();
    drive_redirect(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 16'hFFFC, 26'h0);
    wait_valid();

    // taken branch while stalled in S_VALID flushes to 0x4000_0008
    lat = 6;
    push_fetch(32'h4000_0008, 1'b0);
    drive_redirect(1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 16'h0002, 26'h0);
    check("flush_valid", instr_valid, 1'b0);
    check("flush_instr", instr, 32'd0);
    check("flush_state", fetch_state, S_REQ);
    wait_req_rise();
    push_fetch(32'h4000_0100, 1'b1);
    drive_redirect(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 26'h40);
    wait_valid();

    // jump together with taken bne: branch target wins
    lat = 1;
    push_fetch(32'h240, 1'b1);
    drive_redirect(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 16'h0010, 26'h100);
    check("both_valid", instr_valid, 1'b0);
    wait_valid();

    // fetch at the top of memory: pc_plus4 wraps to 0
    lat = $urandom_range(1, 3);
    push_fetch(32'hFFFF_FFFC, 1'b1);
    drive_redirect(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 16'h0000, 26'h0);
    wait_valid();

    // reset mid S_WAIT with a late ack landing during reset
    lat = 30;
    push_fetch(32'h0, 1'b0);
    release_stall();
    wait_req_rise();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("midrst");
    @(negedge clk);
    lat = 1;
    push_fetch(32'h0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_addr", imem_addr, 32'h0);
    wait_valid();

    repeat (4) @(negedge clk);
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("out_q_empty", exp_out_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
